// File: rtl/control_unit.sv
// Multicycle control FSM for the 16-bit CPU: fetches into an internal IR, decodes, and
// sequences ALU op, register-file, PC and memory enables one instruction at a time.
module control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_neg,
    input  logic        alu_zero,
    output logic [3:0]  alu_op,
    output logic [11:0] inst12,
    output logic [3:0]  rf_ra,
    output logic [3:0]  rf_rb,
    output logic [3:0]  rf_wa,
    output logic        rf_we,
    output logic        wdata_sel,
    output logic        pc_we,
    output logic        addr_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        retire,
    output logic        halted
);

    localparam logic [3:0] OpLi       = 4'd7;
    localparam logic [3:0] OpLd       = 4'd8;
    localparam logic [3:0] OpSt       = 4'd9;
    localparam logic [3:0] OpBz       = 4'd10;
    localparam logic [3:0] OpBn       = 4'd11;
    localparam logic [3:0] OpJ        = 4'd12;
    localparam logic [3:0] OpJr       = 4'd13;
    localparam logic [3:0] OpNop      = 4'd14;
    localparam logic [3:0] AluPcInc   = 4'd10;
    localparam logic [3:0] AluBrTaken = 4'd11;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StBranch,
        StPcinc,
        StHalt
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       rf_we;
        logic       pc_we;
        logic       addr_sel;
        logic       mem_req;
        logic       mem_we;
        logic       retire;
        logic       halted;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q;
    logic [3:0]  opcode;
    logic        br_taken;
    logic        ld_done;

    assign opcode = ir_q[15:12];

    // Moore outputs for the state being entered; registered so reset forces them low.
    function automatic ctrl_t moore_ctrl(input state_t st, input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.mem_req = 1'b1;
            end
            StExec: begin
                c.alu_op = op;
                c.rf_we  = 1'b1;
            end
            StMem: begin
                c.alu_op   = op;
                c.addr_sel = 1'b1;
                c.mem_req  = 1'b1;
                c.mem_we   = (op == OpSt);
            end
            StBranch: begin
                c.alu_op = (op >= OpJ) ? op : AluPcInc;
                c.pc_we  = 1'b1;
                c.retire = 1'b1;
            end
            StPcinc: begin
                c.alu_op = AluPcInc;
                c.pc_we  = 1'b1;
                c.retire = 1'b1;
            end
            StHalt: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            StFetch: begin
                // The first cycle after reset has mem_req low, so no data is accepted then.
                if (ctrl_q.mem_req && mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode <= OpLi) begin
                    state_d = StExec;
                end else if (opcode == OpLd || opcode == OpSt) begin
                    state_d = StMem;
                end else if (opcode <= OpJr) begin
                    state_d = StBranch;
                end else if (opcode == OpNop) begin
                    state_d = StPcinc;
                end else begin
                    state_d = StHalt;
                end
            end
            StExec: begin
                state_d = StPcinc;
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = StPcinc;
                end
            end
            StBranch, StPcinc: begin
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            ir_q    <= 16'h0000;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= moore_ctrl(state_d, ir_d[15:12]);
        end
    end

    // Branch direction and load write-back are resolved in-cycle from the flags / ready.
    assign br_taken = (state_q == StBranch) &&
                      ((opcode == OpBz && alu_zero) || (opcode == OpBn && alu_neg));
    assign ld_done  = (state_q == StMem) && (opcode == OpLd) && mem_ready;

    assign alu_op    = br_taken ? AluBrTaken : ctrl_q.alu_op;
    assign rf_we     = ctrl_q.rf_we | ld_done;
    assign wdata_sel = ld_done;
    assign pc_we     = ctrl_q.pc_we;
    assign addr_sel  = ctrl_q.addr_sel;
    assign mem_req   = ctrl_q.mem_req;
    assign mem_we    = ctrl_q.mem_we;
    assign retire    = ctrl_q.retire;
    assign halted    = ctrl_q.halted;

    assign inst12 = ir_q[11:0];
    assign rf_wa  = ir_q[11:8];
    assign rf_ra  = ir_q[7:4];
    assign rf_rb  = ir_q[3:0];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, random instruction stream against an
// instruction-level cycle model, and reset corner cases.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        alu_neg = 1'b0;
    logic        alu_zero = 1'b0;
    logic [3:0]  alu_op;
    logic [11:0] inst12;
    logic [3:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_we, wdata_sel, pc_we, addr_sel, mem_req, mem_we, retire, halted;

    control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .alu_neg   (alu_neg),
        .alu_zero  (alu_zero),
        .alu_op    (alu_op),
        .inst12    (inst12),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_wa     (rf_wa),
        .rf_we     (rf_we),
        .wdata_sel (wdata_sel),
        .pc_we     (pc_we),
        .addr_sel  (addr_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .retire    (retire),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // {rf_we, wdata_sel, pc_we, addr_sel, mem_req, mem_we, retire, halted}
    logic [7:0] ctl_bus;
    assign ctl_bus = {rf_we, wdata_sel, pc_we, addr_sel, mem_req, mem_we, retire, halted};

    int          total = 0;
    int          bad = 0;
    int          cyc_cnt;
    int          retire_at;
    logic [3:0]  last_alu;
    logic [15:0] model_ir = 16'h0000;

    typedef struct {
        logic [15:0] instr;
        int          fw;
        int          mw;
        bit          z;
        bit          n;
        int          exp_cyc;
        logic [3:0]  exp_alu;
    } vec_t;

    vec_t vecs[13];

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs are already driven for this cycle; check at negedge, then step past posedge.
    task automatic check_cycle(input string tag, input logic [7:0] exp_ctl, input bit chk_alu,
                               input logic [3:0] exp_alu);
        @(negedge clk);
        cmp({tag, ".ctl"}, {8'h00, ctl_bus}, {8'h00, exp_ctl});
        if (chk_alu) cmp({tag, ".alu_op"}, {12'h000, alu_op}, {12'h000, exp_alu});
        cmp({tag, ".inst12"}, {4'h0, inst12}, {4'h0, model_ir[11:0]});
        cmp({tag, ".rf_addr"}, {4'h0, rf_wa, rf_ra, rf_rb}, {4'h0, model_ir[11:0]});
        last_alu = alu_op;
        cyc_cnt++;
        if (retire === 1'b1 && retire_at < 0) retire_at = cyc_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic pcinc_cycle();
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        check_cycle("pcinc", 8'h22, 1'b1, 4'd10);
    endtask

    // Instruction-level model: expected per-cycle outputs follow directly from the opcode class.
    task automatic run_instr(input logic [15:0] instr, input int fw, input int mw, input bit z,
                             input bit n, output int ret_cyc, output logic [3:0] key_alu);
        logic [3:0] op;
        logic [7:0] exp;
        logic [3:0] br_alu;
        op = instr[15:12];
        cyc_cnt = 0;
        retire_at = -1;
        key_alu = 4'h0;
        for (int w = 0; w <= fw; w++) begin
            mem_rdata = instr;
            mem_ready = (w == fw);
            alu_zero  = 1'($urandom);
            alu_neg   = 1'($urandom);
            check_cycle("fetch", 8'h08, 1'b0, 4'h0);
        end
        model_ir = instr;
        mem_ready = 1'($urandom);
        mem_rdata = 16'($urandom);
        check_cycle("decode", 8'h00, 1'b0, 4'h0);
        if (op <= 4'd7) begin
            mem_ready = 1'($urandom);
            check_cycle("exec", 8'h80, 1'b1, op);
            key_alu = last_alu;
            pcinc_cycle();
        end else if (op == 4'd8 || op == 4'd9) begin
            for (int w = 0; w <= mw; w++) begin
                mem_ready = (w == mw);
                mem_rdata = 16'($urandom);
                exp = 8'h18;
                if (op == 4'd9) exp = exp | 8'h04;
                if (op == 4'd8 && w == mw) exp = exp | 8'hC0;
                check_cycle("mem", exp, 1'b1, op);
                if (w == 0) key_alu = last_alu;
            end
            pcinc_cycle();
        end else if (op <= 4'd13) begin
            alu_zero = z;
            alu_neg  = n;
            mem_ready = 1'($urandom);
            if (op >= 4'd12) br_alu = op;
            else if ((op == 4'd10 && z) || (op == 4'd11 && n)) br_alu = 4'd11;
            else br_alu = 4'd10;
            check_cycle("branch", 8'h22, 1'b1, br_alu);
            key_alu = last_alu;
        end else if (op == 4'd14) begin
            pcinc_cycle();
            key_alu = last_alu;
        end else begin
            for (int k = 0; k < 5; k++) begin
                mem_ready = 1'($urandom);
                mem_rdata = 16'($urandom);
                check_cycle("halt", 8'h01, 1'b0, 4'h0);
            end
        end
        ret_cyc = retire_at;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hF000;
        @(negedge clk);
        cmp("reset.ctl", {8'h00, ctl_bus}, 16'h0000);
        cmp("reset.alu_op", {12'h000, alu_op}, 16'h0000);
        cmp("reset.inst12", {4'h0, inst12}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_ir = 16'h0000;
        cyc_cnt = 0;
        retire_at = -1;
        // Released but not yet clocked: mem_req must still be low and data ignored.
        check_cycle("post_reset", 8'h00, 1'b1, 4'h0);
    endtask

    initial begin
        int         rc;
        logic [3:0] ka;
        logic [15:0] ri;

        vecs[0]  = '{16'h0312, 0, 0, 1'b0, 1'b0, 4, 4'd0};
        vecs[1]  = '{16'h1456, 1, 0, 1'b0, 1'b0, 5, 4'd1};
        vecs[2]  = '{16'h5213, 0, 0, 1'b0, 1'b0, 4, 4'd5};
        vecs[3]  = '{16'h70AB, 0, 0, 1'b0, 1'b0, 4, 4'd7};
        vecs[4]  = '{16'h8253, 0, 2, 1'b0, 1'b0, 6, 4'd8};
        vecs[5]  = '{16'h9A13, 0, 2, 1'b0, 1'b0, 6, 4'd9};
        vecs[6]  = '{16'hA0F4, 0, 0, 1'b1, 1'b0, 3, 4'd11};
        vecs[7]  = '{16'hA0F4, 0, 0, 1'b0, 1'b1, 3, 4'd10};
        vecs[8]  = '{16'hB0F4, 0, 0, 1'b0, 1'b1, 3, 4'd11};
        vecs[9]  = '{16'hB0F4, 0, 0, 1'b1, 1'b0, 3, 4'd10};
        vecs[10] = '{16'hC123, 0, 0, 1'b0, 1'b0, 3, 4'd12};
        vecs[11] = '{16'hD050, 0, 0, 1'b0, 1'b0, 3, 4'd13};
        vecs[12] = '{16'hE000, 2, 0, 1'b0, 1'b0, 5, 4'd10};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i].instr, vecs[i].fw, vecs[i].mw, vecs[i].z, vecs[i].n, rc, ka);
            cmp($sformatf("vec%0d.cycles", i), 16'(rc), 16'(vecs[i].exp_cyc));
            cmp($sformatf("vec%0d.key_alu", i), {12'h000, ka}, {12'h000, vecs[i].exp_alu});
        end

        for (int i = 0; i < 150; i++) begin
            ri = 16'($urandom);
            ri[15:12] = 4'($urandom_range(0, 14));
            run_instr(ri, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom), rc, ka);
        end

        // HALT is terminal: no further requests.
        run_instr(16'hF000, 0, 0, 1'b0, 1'b0, rc, ka);
        cmp("halt.no_retire", 16'(rc), 16'hFFFF);

        // Reset mid-FETCH with memory stalled drops mem_req asynchronously.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            mem_ready = 1'b0;
            mem_rdata = 16'h0312;
            check_cycle("stall_fetch", 8'h08, 1'b0, 4'h0);
        end
        rst_n = 1'b0;
        #1;
        cmp("async_drop.mem_req", {15'h0, mem_req}, 16'h0000);
        do_reset();
        run_instr(16'h0312, 0, 0, 1'b0, 1'b0, rc, ka);
        cmp("restart.cycles", 16'(rc), 16'd4);

        // Reset during a completing LD must not produce an RF write.
        mem_ready = 1'b1;
        mem_rdata = 16'h8253;
        check_cycle("ld_fetch", 8'h08, 1'b0, 4'h0);
        model_ir = 16'h8253;
        check_cycle("ld_decode", 8'h00, 1'b0, 4'h0);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        cmp("abandon.ctl", {8'h00, ctl_bus}, 16'h0000);
        do_reset();
        run_instr(16'h9A13, 1, 1, 1'b0, 1'b0, rc, ka);
        cmp("after_abandon.cycles", 16'(rc), 16'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
